uart_gpio_responder: RTL

- Host-side peer for the Murax UART: it sits on the far end of the SoC's tx/rx pair and talks to it over 8N1 serial.
- It receives command bytes, writes a 16-bit LED register, reads a 16-bit switch snapshot, and sends the response bytes back.
- It is used on the board or in the bench as the responder opposite the SoC firmware, so UART and GPIO paths can be exercised without a PC.

---
 rtl/uart_gpio_responder.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_gpio_responder.sv
// 8N1 UART peer: 'W' hi lo writes led and answers ACK, 'R' answers sw, anything else NAK.
// Define UART_RESP_TIMEOUT_EN to abandon a half-received write after 16 bit times.
module uart_gpio_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TXQ_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        framing_err,
  output logic        overrun
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned QAW = $clog2(TXQ_DEPTH);
  localparam int unsigned QCW = QAW + 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_WHI, P_WLO} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_s1, rx_s2, rx_tick, rx_ok, rx_bad, rx_valid;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tick      = 1'b0;
    rx_ok        = 1'b0;
    rx_bad       = 1'b0;
    case (rx_state)
      R_IDLE:  if (!rx_s2) rx_state_nxt = R_START;
      R_START: if (rx_cnt == HALF_M1) begin
        rx_tick      = 1'b1;
        rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA:  if (rx_cnt == FULL_M1) begin
        rx_tick = 1'b1;
        if (rx_bit == 3'd7) rx_state_nxt = R_STOP;
      end
      R_STOP:  if (rx_cnt == FULL_M1) begin
        rx_tick      = 1'b1;
        rx_ok        = rx_s2;
        rx_bad       = !rx_s2;
        rx_state_nxt = R_IDLE;
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_state    <= rx_state_nxt;
      rx_valid    <= rx_ok;
      framing_err <= rx_bad;
      rx_cnt      <= (rx_state == R_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_state == R_IDLE) rx_bit <= '0;
      if (rx_state == R_DATA && rx_tick) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
    end
  end

  // ---------------- parser ----------------
  p_state_t       p_state, p_state_nxt;
  logic [7:0]     hi_byte, resp_b0, resp_b1;
  logic [1:0]     resp_len, push_n;
  logic           led_we, hi_we, ov_nxt;
  logic [QCW-1:0] q_cnt, q_free;
  logic           q_pop;

  assign q_free = QCW'(TXQ_DEPTH) - q_cnt;

`ifdef UART_RESP_TIMEOUT_EN
  localparam int unsigned TMO = 16 * CLKS_PER_BIT;
  localparam int unsigned TW  = $clog2(TMO);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_exp;

  assign tmo_exp = (p_state != P_IDLE) && (tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_valid || p_state == P_IDLE) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_comb begin
    p_state_nxt = p_state;
    resp_len    = 2'd0;
    resp_b0     = 8'h00;
    resp_b1     = 8'h00;
    led_we      = 1'b0;
    hi_we       = 1'b0;
    ov_nxt      = 1'b0;
    push_n      = 2'd0;
    if (framing_err) begin
      p_state_nxt = P_IDLE;
    end else if (rx_valid) begin
      case (p_state)
        P_IDLE: begin
          if (rx_sh == 8'h57) begin
            p_state_nxt = P_WHI;
          end else if (rx_sh == 8'h52) begin
            resp_len = 2'd2;
            resp_b0  = sw[15:8];
            resp_b1  = sw[7:0];
          end else begin
            resp_len = 2'd1;
            resp_b0  = 8'h15;
          end
        end
        P_WHI: begin
          hi_we       = 1'b1;
          p_state_nxt = P_WLO;
        end
        P_WLO: begin
          led_we      = 1'b1;
          resp_len    = 2'd1;
          resp_b0     = 8'h06;
          p_state_nxt = P_IDLE;
        end
        default: p_state_nxt = P_IDLE;
      endcase
`ifdef UART_RESP_TIMEOUT_EN
    end else if (tmo_exp) begin
      p_state_nxt = P_IDLE;
      resp_len    = 2'd1;
      resp_b0     = 8'h15;
`endif
    end
    // Responses are all-or-nothing; free space is judged before any same-cycle pop.
    if (resp_len != 2'd0) begin
      if (q_free < QCW'(resp_len)) ov_nxt = 1'b1;
      else                         push_n = resp_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state <= P_IDLE;
      hi_byte <= '0;
      led     <= '0;
      overrun <= 1'b0;
    end else begin
      p_state <= p_state_nxt;
      overrun <= ov_nxt;
      if (hi_we)  hi_byte <= rx_sh;
      if (led_we) led     <= {hi_byte, rx_sh};
    end
  end

  // ---------------- response queue ----------------
  logic [7:0]     q_mem [TXQ_DEPTH];
  logic [QAW-1:0] q_wp, q_rp;

  always_ff @(posedge clk) begin
    if (push_n != 2'd0) q_mem[q_wp] <= resp_b0;
    if (push_n == 2'd2) q_mem[q_wp + 1'b1] <= resp_b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      q_wp  <= q_wp + QAW'(push_n);
      if (q_pop) q_rp <= q_rp + 1'b1;
      q_cnt <= q_cnt + QCW'(push_n) - QCW'(q_pop);
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t     t_state, t_state_nxt;
  logic [CW-1:0] t_cnt;
  logic [2:0]    t_bit;
  logic [7:0]    t_sh;
  logic          t_tick;

  always_comb begin
    t_state_nxt = t_state;
    t_tick      = 1'b0;
    q_pop       = 1'b0;
    case (t_state)
      T_IDLE: if (q_cnt != '0) begin
        q_pop       = 1'b1;
        t_state_nxt = T_START;
      end
      T_START: if (t_cnt == FULL_M1) begin
        t_tick      = 1'b1;
        t_state_nxt = T_DATA;
      end
      T_DATA: if (t_cnt == FULL_M1) begin
        t_tick = 1'b1;
        if (t_bit == 3'd7) t_state_nxt = T_STOP;
      end
      T_STOP: if (t_cnt == FULL_M1) begin
        t_tick      = 1'b1;
        t_state_nxt = T_IDLE;
      end
      default: t_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state <= T_IDLE;
      t_cnt   <= '0;
      t_bit   <= '0;
      t_sh    <= '0;
    end else begin
      t_state <= t_state_nxt;
      t_cnt   <= (t_state == T_IDLE || t_tick) ? '0 : t_cnt + 1'b1;
      if (q_pop) begin
        t_sh  <= q_mem[q_rp];
        t_bit <= '0;
      end else if (t_state == T_DATA && t_tick) begin
        t_sh  <= {1'b0, t_sh[7:1]};
        t_bit <= t_bit + 1'b1;
      end
    end
  end

  assign tx = (t_state == T_START) ? 1'b0 :
              (t_state == T_DATA)  ? t_sh[0] : 1'b1;

endmodule
